// File: rtl/ibus_arbiter_pkg.sv
// ibus_arbiter_pkg: shared port identifiers and bus widths for the instruction-bus read arbiter
package ibus_arbiter_pkg;
  typedef enum logic {PORT_FETCH, PORT_LOAD} port_t;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
endpackage

// File: rtl/ibus_arbiter_id_fifo.sv
// id_fifo: in-order owner-id FIFO with async active-low reset
module id_fifo
  import ibus_arbiter_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  port_t         i_din,
  output port_t         o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);
  port_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wr_nxt, w_rd_nxt;
  // explicit wrap keeps non-power-of-two-free depths such as 1 correct
  assign w_wr_nxt = (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
  assign w_rd_nxt = (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= w_wr_nxt;
      if (i_pop) r_rd <= w_rd_nxt;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  always_ff @(posedge i_clk)
    if (i_push) r_mem[r_wr] <= i_din;
  assign o_dout  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
endmodule

// File: rtl/ibus_arbiter.sv
// ibus_arbiter: round-robin two-master AXI4 read arbiter with in-order R steering
module ibus_arbiter
  import ibus_arbiter_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 2,
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic              i_aclk,
  input  logic              i_aresetn,
  input  logic              i_s0_arvalid,
  output logic              o_s0_arready,
  input  logic [ADDR_W-1:0] i_s0_araddr,
  input  logic [2:0]        i_s0_arprot,
  output logic              o_s0_rvalid,
  input  logic              i_s0_rready,
  output logic [DATA_W-1:0] o_s0_rdata,
  output logic [1:0]        o_s0_rresp,
  input  logic              i_s1_arvalid,
  output logic              o_s1_arready,
  input  logic [ADDR_W-1:0] i_s1_araddr,
  input  logic [2:0]        i_s1_arprot,
  output logic              o_s1_rvalid,
  input  logic              i_s1_rready,
  output logic [DATA_W-1:0] o_s1_rdata,
  output logic [1:0]        o_s1_rresp,
  output logic              o_m_arvalid,
  input  logic              i_m_arready,
  output logic [ADDR_W-1:0] o_m_araddr,
  output logic [2:0]        o_m_arprot,
  input  logic              i_m_rvalid,
  output logic              o_m_rready,
  input  logic [DATA_W-1:0] i_m_rdata,
  input  logic [1:0]        i_m_rresp,
  output logic              o_s0_awready,
  output logic              o_s0_wready,
  output logic              o_s0_bvalid,
  output logic              o_s1_awready,
  output logic              o_s1_wready,
  output logic              o_s1_bvalid,
  output logic              o_m_awvalid,
  output logic              o_m_wvalid,
  output logic              o_m_bready,
  output logic [CW-1:0]     o_outstanding
);
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arprot;
  port_t             r_last;
  logic              w_load, w_req, w_push, w_pop, w_empty, w_full, w_head_rready;
  port_t             w_grant, w_head;
  // full counts the entry still sitting in the AR register, so a pop never frees a slot this cycle
  assign w_load  = i_aresetn & (~r_arvalid | i_m_arready) & ~w_full;
  assign w_req   = i_s0_arvalid | i_s1_arvalid;
  assign w_grant = (i_s0_arvalid & i_s1_arvalid) ? ((r_last == PORT_FETCH) ? PORT_LOAD : PORT_FETCH)
                                                 : (i_s1_arvalid ? PORT_LOAD : PORT_FETCH);
  assign w_push  = w_load & w_req;
  assign o_s0_arready = w_push & (w_grant == PORT_FETCH);
  assign o_s1_arready = w_push & (w_grant == PORT_LOAD);
  always_ff @(posedge i_aclk or negedge i_aresetn)
    if (!i_aresetn) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arprot  <= '0;
      r_last    <= PORT_LOAD;
    end else if (w_push) begin
      r_arvalid <= 1'b1;
      r_araddr  <= (w_grant == PORT_LOAD) ? i_s1_araddr : i_s0_araddr;
      r_arprot  <= (w_grant == PORT_LOAD) ? i_s1_arprot : i_s0_arprot;
      r_last    <= w_grant;
    end else if (i_m_arready) begin
      r_arvalid <= 1'b0;
    end
  assign o_m_arvalid = r_arvalid;
  assign o_m_araddr  = r_araddr;
  assign o_m_arprot  = r_arprot;
  id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .i_clk   (i_aclk),
    .i_rst_n (i_aresetn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_grant),
    .o_dout  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (o_outstanding)
  );
  assign w_head_rready = (w_head == PORT_LOAD) ? i_s1_rready : i_s0_rready;
  assign o_m_rready    = ~w_empty & w_head_rready;
  assign o_s0_rvalid   = i_m_rvalid & ~w_empty & (w_head == PORT_FETCH);
  assign o_s1_rvalid   = i_m_rvalid & ~w_empty & (w_head == PORT_LOAD);
  assign o_s0_rdata    = i_m_rdata;
  assign o_s1_rdata    = i_m_rdata;
  assign o_s0_rresp    = i_m_rresp;
  assign o_s1_rresp    = i_m_rresp;
  assign w_pop         = i_m_rvalid & o_m_rready;
  assign o_s0_awready  = 1'b0;
  assign o_s0_wready   = 1'b0;
  assign o_s0_bvalid   = 1'b0;
  assign o_s1_awready  = 1'b0;
  assign o_s1_wready   = 1'b0;
  assign o_s1_bvalid   = 1'b0;
  assign o_m_awvalid   = 1'b0;
  assign o_m_wvalid    = 1'b0;
  assign o_m_bready    = 1'b1;
endmodule

// File: tb/tb_ibus_arbiter.sv
// tb_ibus_arbiter: directed checks of grant order, AR backpressure, outstanding limit, R steering and async reset
module tb_ibus_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic        s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0] s0_araddr, s1_araddr, s0_rdata, s1_rdata;
  logic [2:0]  s0_arprot, s1_arprot, m_arprot;
  logic [1:0]  s0_rresp, s1_rresp, m_rresp;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_araddr, m_rdata;
  logic        s0_awready, s0_wready, s0_bvalid, s1_awready, s1_wready, s1_bvalid;
  logic        m_awvalid, m_wvalid, m_bready;
  logic [1:0]  count;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  ibus_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .i_aclk(clk), .i_aresetn(rst_n),
    .i_s0_arvalid(s0_arvalid), .o_s0_arready(s0_arready), .i_s0_araddr(s0_araddr), .i_s0_arprot(s0_arprot),
    .o_s0_rvalid(s0_rvalid), .i_s0_rready(s0_rready), .o_s0_rdata(s0_rdata), .o_s0_rresp(s0_rresp),
    .i_s1_arvalid(s1_arvalid), .o_s1_arready(s1_arready), .i_s1_araddr(s1_araddr), .i_s1_arprot(s1_arprot),
    .o_s1_rvalid(s1_rvalid), .i_s1_rready(s1_rready), .o_s1_rdata(s1_rdata), .o_s1_rresp(s1_rresp),
    .o_m_arvalid(m_arvalid), .i_m_arready(m_arready), .o_m_araddr(m_araddr), .o_m_arprot(m_arprot),
    .i_m_rvalid(m_rvalid), .o_m_rready(m_rready), .i_m_rdata(m_rdata), .i_m_rresp(m_rresp),
    .o_s0_awready(s0_awready), .o_s0_wready(s0_wready), .o_s0_bvalid(s0_bvalid),
    .o_s1_awready(s1_awready), .o_s1_wready(s1_wready), .o_s1_bvalid(s1_bvalid),
    .o_m_awvalid(m_awvalid), .o_m_wvalid(m_wvalid), .o_m_bready(m_bready),
    .o_outstanding(count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    {s0_arvalid, s1_arvalid, m_arready, m_rvalid} = '0;
    {s0_araddr, s1_araddr, m_rdata} = '0;
    {s0_arprot, s1_arprot, m_rresp} = '0;
    s0_rready = 1'b1;
    s1_rready = 1'b1;
    nxt();
    s0_arvalid = 1'b1; s0_araddr = 32'h100; s0_arprot = 3'd2; m_arready = 1'b1; m_rvalid = 1'b1;
    #1;
    chk("rst_arvalid", 32'(m_arvalid), 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_arprot", 32'(m_arprot), 0);
    chk("rst_s0_arready", 32'(s0_arready), 0);
    chk("rst_s0_rvalid", 32'(s0_rvalid), 0);
    chk("rst_count", 32'(count), 0);
    chk("tieoffs", 32'({s0_awready, s0_wready, s0_bvalid, s1_awready, s1_wready, s1_bvalid, m_awvalid, m_wvalid, m_bready}), 32'h1);
    m_rvalid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("t1_s0_arready", 32'(s0_arready), 1);
    chk("t1_s1_arready", 32'(s1_arready), 0);
    nxt();
    s0_arvalid = 1'b0;
    #1;
    chk("t1_m_arvalid", 32'(m_arvalid), 1);
    chk("t1_m_araddr", m_araddr, 32'h100);
    chk("t1_m_arprot", 32'(m_arprot), 2);
    chk("t1_count", 32'(count), 1);
    m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; m_rresp = 2'd1;
    #1;
    chk("t1_s0_rvalid", 32'(s0_rvalid), 1);
    chk("t1_s0_rdata", s0_rdata, 32'hDEADBEEF);
    chk("t1_s0_rresp", 32'(s0_rresp), 1);
    chk("t1_s1_rvalid", 32'(s1_rvalid), 0);
    chk("t1_m_rready", 32'(m_rready), 1);
    nxt();
    m_rvalid = 1'b0; m_rresp = 2'd0;
    #1;
    chk("t1_count_after", 32'(count), 0);
    chk("t1_arvalid_clr", 32'(m_arvalid), 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    s0_arvalid = 1'b1; s0_araddr = 32'h200;
    s1_arvalid = 1'b1; s1_araddr = 32'h300;
    #1;
    chk("rr_g0_s0", 32'(s0_arready), 1);
    chk("rr_g0_s1", 32'(s1_arready), 0);
    nxt(); #1;
    chk("rr_g1_s1", 32'(s1_arready), 1);
    chk("rr_g1_s0", 32'(s0_arready), 0);
    chk("rr_g1_addr", m_araddr, 32'h200);
    nxt(); #1;
    chk("lim_s0", 32'(s0_arready), 0);
    chk("lim_s1", 32'(s1_arready), 0);
    chk("lim_addr", m_araddr, 32'h300);
    chk("lim_count", 32'(count), 2);
    nxt(); #1;
    chk("lim2_arready", 32'({s0_arready, s1_arready}), 0);
    chk("lim2_arvalid", 32'(m_arvalid), 0);
    m_rvalid = 1'b1; m_rdata = 32'hA0;
    #1;
    chk("r0_s0_rvalid", 32'(s0_rvalid), 1);
    chk("r0_s1_rvalid", 32'(s1_rvalid), 0);
    chk("r0_no_same_cycle_grant", 32'(s0_arready), 0);
    nxt();
    m_rdata = 32'hA1;
    #1;
    chk("r1_s1_rvalid", 32'(s1_rvalid), 1);
    chk("r1_s0_rvalid", 32'(s0_rvalid), 0);
    chk("r1_s1_rdata", s1_rdata, 32'hA1);
    chk("rr_g2_s0", 32'(s0_arready), 1);
    chk("rr_g2_s1", 32'(s1_arready), 0);
    nxt();
    s0_arvalid = 1'b0; s1_arvalid = 1'b0; m_rdata = 32'hA2;
    #1;
    chk("pushpop_count", 32'(count), 1);
    chk("r2_addr", m_araddr, 32'h200);
    chk("r2_s0_rvalid", 32'(s0_rvalid), 1);
    nxt();
    m_rvalid = 1'b0; m_arready = 1'b0;
    s1_arvalid = 1'b1; s1_araddr = 32'h400;
    #1;
    chk("bp_grant", 32'(s1_arready), 1);
    nxt();
    s1_araddr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_arvalid", 32'(m_arvalid), 1);
      chk("bp_addr", m_araddr, 32'h400);
      chk("bp_arready", 32'({s0_arready, s1_arready}), 0);
      nxt();
    end
    m_arready = 1'b1;
    #1;
    chk("bp_resume", 32'(s1_arready), 1);
    nxt();
    s1_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'hB0; s1_rready = 1'b0;
    #1;
    chk("stall_m_rready", 32'(m_rready), 0);
    chk("stall_s0_rvalid", 32'(s0_rvalid), 0);
    chk("stall_s1_rvalid", 32'(s1_rvalid), 1);
    chk("stall_addr", m_araddr, 32'h500);
    nxt(); #1;
    chk("stall_count", 32'(count), 2);
    chk("stall_arvalid", 32'(m_arvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_arvalid", 32'(m_arvalid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_m_rready", 32'(m_rready), 0);
    chk("arst_s1_rvalid", 32'(s1_rvalid), 0);
    rst_n = 1'b1; m_rvalid = 1'b0; m_arready = 1'b1; s1_rready = 1'b1;
    s0_arvalid = 1'b1; s0_araddr = 32'h600; s1_arvalid = 1'b1;
    #1;
    chk("arst_first_s0", 32'(s0_arready), 1);
    chk("arst_first_s1", 32'(s1_arready), 0);
    nxt(); #1;
    chk("arst_addr", m_araddr, 32'h600);
    chk("arst_count_after", 32'(count), 1);
    s0_arvalid = 1'b0; s1_arvalid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
